hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32: datapath width.
REQ-002 SHALL provide parameter AW, default 5: register address width.
REQ-003 SHALL provide parameter LD_LAT, default 1, legal 1..4: load-use stall cycles.
REQ-004 SHALL provide parameter CNT_W, default 32: stall-cycle counter width.
REQ-005 SHALL have ports in this order: clk  in  1  sole clock, rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 id_valid  in  1  decode stage holds a valid instruction.
REQ-008 id_rs1, id_rs2  in  AW  decode source addresses.
REQ-009 id_rs1_used, id_rs2_used  in  1  the source is actually read.
REQ-010 rf_rs1, rf_rs2  in  XLEN  register-file read data.
REQ-011 ex_regw, ex_is_load  in  1  execute-stage writes rd / is a load.
REQ-012 ex_rd  in  AW; ex_result  in  XLEN  execute-stage destination and ALU result.
REQ-013 wb_regw  in  1; wb_rd  in  AW; wb_data  in  XLEN  writeback-stage write.
REQ-014 branch_taken  in  1  redirect resolved in execute.
REQ-015 fwd_rs1, fwd_rs2  out  XLEN  resolved operands, combinational.
REQ-016 stall_if, stall_id, bubble_ex, flush_id  out  1  pipeline control, registered state, combinational decode.
REQ-017 stall_cycles  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-018 Operand source priority, per rsN: rsN==0 -> 0; EX match (ex_regw, !ex_is_load, ex_rd==rsN) -> ex_result; WB match (wb_regw, wb_rd==rsN) -> wb_data; HOLD match -> hold data; else rf_rsN.
REQ-019 SHALL keep a hold register {hold_v, hold_rd, hold_data} loaded every cycle with {wb_regw && wb_rd!=0, wb_rd, wb_data}; covers registered regfile read-after-write.
REQ-020 Writes to x0 SHALL never forward or load the hold register.
REQ-021 Load-use hazard = id_valid && ex_regw && ex_is_load && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
REQ-022 FSM states: IDLE, LDSTALL, FLUSH; 3-bit or fewer encoding, implementer's choice.
REQ-023 IDLE: hazard && !branch_taken -> LDSTALL, counter loaded LD_LAT-1; stall_if=stall_id=bubble_ex=1 in that same cycle (combinational from hazard).
REQ-024 LDSTALL: stall_if=stall_id=bubble_ex=1; counter decrements; at counter==0 -> IDLE next cycle.
REQ-025 Total stall per load-use SHALL be exactly LD_LAT cycles; LD_LAT=1 means LDSTALL is never entered.
REQ-026 branch_taken in any state: flush_id=1, bubble_ex=1, stall_if=stall_id=0 that cycle; next state FLUSH; pending stall cancelled.
REQ-027 FLUSH: one cycle, all controls 0, hazard detection suppressed; -> IDLE.
REQ-028 branch_taken while in FLUSH SHALL re-enter FLUSH (back-to-back redirects).
REQ-029 stall_cycles SHALL increment by 1 each cycle stall_id=1, saturating at all-ones, no wrap.
REQ-030 Forwarding SHALL stay active during stalls so the stalled instruction picks up load data from WB/HOLD.

Reset
REQ-031 rstn low SHALL asynchronously force: state IDLE, counter 0, hold_v 0, hold_rd 0, hold_data 0, stall_cycles 0.
REQ-032 During reset stall_if, stall_id, bubble_ex, flush_id SHALL read 0; fwd_rsN pass rf_rsN (or 0 for x0).
REQ-033 Reset release SHALL be synchronous to clk; first active edge evaluates inputs normally.
REQ-034 Reset asserted mid-LDSTALL SHALL abort the stall immediately; no residual stall after release.

Verification
REQ-035 ex_rd=5, ex_regw=1, ex_is_load=0, ex_result=0xDEAD0001, id_rs1=5 used -> fwd_rs1=0xDEAD0001, no stall.
REQ-036 EX and WB both target x7 (0x11, 0x22), id_rs2=7 -> fwd_rs2=0x11; id_rs1=0 with EX rd=0 -> fwd_rs1=0.
REQ-037 LD_LAT=3, load to x9 in EX, id_rs1=9 -> stall_id high exactly 3 cycles, stall_cycles +3, then fwd_rs1=wb/hold data.
REQ-038 branch_taken in 2nd cycle of a LD_LAT=3 stall -> flush_id=1, stall drops same cycle, FLUSH one cycle, IDLE.
REQ-039 WB writes x3=0xA5A5A5A5, next cycle rf_rs1 stale 0, id_rs1=3 -> fwd_rs1=0xA5A5A5A5 via hold.
REQ-040 CNT_W=4, 20 stall cycles -> stall_cycles saturates at 15; rstn pulse mid-stall -> all outputs 0, counter 0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit for an in-order pipeline.
// Resolves decode-stage operands from EX, WB or a one-entry hold register.
// Generates load-use stalls of LD_LAT cycles and one-cycle branch flushes.
module hazard_fwd_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned LD_LAT = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [XLEN-1:0]  rf_rs1,
  input  logic [XLEN-1:0]  rf_rs2,
  input  logic             ex_regw,
  input  logic             ex_is_load,
  input  logic [AW-1:0]    ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             wb_regw,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             branch_taken,
  output logic [XLEN-1:0]  fwd_rs1,
  output logic [XLEN-1:0]  fwd_rs2,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_cycles
);

  // Remaining-stall counter only needs to reach LD_LAT-1 (at most 3).
  localparam int unsigned LCW = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LDSTALL = 2'd1,
    S_FLUSH   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LCW-1:0]   cnt_q, cnt_d;
  logic             hold_v_q;
  logic [AW-1:0]    hold_rd_q;
  logic [XLEN-1:0]  hold_data_q;
  logic [CNT_W-1:0] stall_cycles_q;

  logic ld_use;
  logic stall_c;
  logic bubble_c;
  logic flush_c;
  logic ex_fwd_en;

  // Operand source selection; reset forces plain regfile data.
  function automatic logic [XLEN-1:0] resolve(
    input logic            live,
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] rf,
    input logic            ex_en,
    input logic [AW-1:0]   exrd,
    input logic [XLEN-1:0] exres,
    input logic            wb_en,
    input logic [AW-1:0]   wbrd,
    input logic [XLEN-1:0] wbd,
    input logic            hv,
    input logic [AW-1:0]   hrd,
    input logic [XLEN-1:0] hd
  );
    logic [XLEN-1:0] r;
    r = rf;
    if (rs == '0)                   r = '0;
    else if (!live)                 r = rf;
    else if (ex_en && exrd == rs)   r = exres;
    else if (wb_en && wbrd == rs)   r = wbd;
    else if (hv && hrd == rs)       r = hd;
    return r;
  endfunction

  assign ex_fwd_en = ex_regw && !ex_is_load;

  // Forwarded operands for both decode sources.
  always_comb begin
    fwd_rs1 = resolve(rstn, id_rs1, rf_rs1, ex_fwd_en, ex_rd, ex_result,
                      wb_regw, wb_rd, wb_data, hold_v_q, hold_rd_q, hold_data_q);
    fwd_rs2 = resolve(rstn, id_rs2, rf_rs2, ex_fwd_en, ex_rd, ex_result,
                      wb_regw, wb_rd, wb_data, hold_v_q, hold_rd_q, hold_data_q);
  end

  assign ld_use = id_valid && ex_regw && ex_is_load && (ex_rd != '0) &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));

  // Next-state and control decode; a taken branch overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (branch_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      state_d  = S_FLUSH;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (LD_LAT > 1) begin
              state_d = S_LDSTALL;
              cnt_d   = LCW'(LD_LAT - 1);
            end
          end
        end
        S_LDSTALL: begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = cnt_q - LCW'(1);
          if (cnt_q <= LCW'(1)) state_d = S_IDLE;
        end
        S_FLUSH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Controls read zero while reset is asserted.
  assign stall_if     = stall_c  && rstn;
  assign stall_id     = stall_c  && rstn;
  assign bubble_ex    = bubble_c && rstn;
  assign flush_id     = flush_c  && rstn;
  assign stall_cycles = stall_cycles_q;

  // FSM state and remaining-stall counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold register covers the regfile's registered read-after-write gap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_v_q    <= 1'b0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
    end else begin
      hold_v_q    <= wb_regw && (wb_rd != '0);
      hold_rd_q   <= wb_rd;
      hold_data_q <= wb_data;
    end
  end

  // Saturating count of decode stall cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles_q <= '0;
    end else if (stall_id && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit (LD_LAT=3, CNT_W=4).
module tb_hazard_fwd_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned LD_LAT = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int          SC_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             id_valid;
  logic [AW-1:0]    id_rs1, id_rs2;
  logic             id_rs1_used, id_rs2_used;
  logic [XLEN-1:0]  rf_rs1, rf_rs2;
  logic             ex_regw, ex_is_load;
  logic [AW-1:0]    ex_rd;
  logic [XLEN-1:0]  ex_result;
  logic             wb_regw;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             branch_taken;
  logic [XLEN-1:0]  fwd_rs1, fwd_rs2;
  logic             stall_if, stall_id, bubble_ex, flush_id;
  logic [CNT_W-1:0] stall_cycles;

  hazard_fwd_unit #(.XLEN(XLEN), .AW(AW), .LD_LAT(LD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .ex_regw(ex_regw), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .wb_regw(wb_regw), .wb_rd(wb_rd), .wb_data(wb_data),
    .branch_taken(branch_taken),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] f1, f2;
    logic            sif, sid, bex, fid;
    int              sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state: cycles of stall still owed, pending flush slot,
  // last cycle's writeback (what the regfile has not yet caught up on).
  int              stall_left = 0;
  bit              flush_pend = 0;
  int              sc_m       = 0;
  bit              last_v     = 0;
  logic [AW-1:0]   last_rd    = '0;
  logic [XLEN-1:0] last_d     = '0;

  task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] ex);
    checks++;
    if (act === ex) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, ex, $time);
  endtask

  function automatic logic [XLEN-1:0] model_src(input logic [AW-1:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 0) return '0;
    if (!rstn) return rf;
    if (ex_regw && !ex_is_load && ex_rd == rs) return ex_result;
    if (wb_regw && wb_rd == rs) return wb_data;
    if (last_v && last_rd == rs) return last_d;
    return rf;
  endfunction

  // Compute the expected response for the inputs now applied, then advance the model.
  task automatic push_exp();
    exp_t e;
    bit   haz;
    e.f1 = model_src(id_rs1, rf_rs1);
    e.f2 = model_src(id_rs2, rf_rs2);
    e.sif = 0; e.sid = 0; e.bex = 0; e.fid = 0;
    if (!rstn) begin
      e.sc = 0;
      stall_left = 0; flush_pend = 0; sc_m = 0;
      last_v = 0; last_rd = '0; last_d = '0;
      exp_q.push_back(e);
      return;
    end
    e.sc = sc_m;
    haz = id_valid && ex_regw && ex_is_load && ex_rd != 0 &&
          ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (branch_taken) begin
      e.fid = 1; e.bex = 1;
      stall_left = 0; flush_pend = 1;
    end else if (stall_left > 0) begin
      e.sif = 1; e.sid = 1; e.bex = 1;
      stall_left--;
    end else if (flush_pend) begin
      flush_pend = 0;
    end else if (haz) begin
      e.sif = 1; e.sid = 1; e.bex = 1;
      stall_left = LD_LAT - 1;
    end
    if (e.sid && sc_m < SC_MAX) sc_m++;
    last_v  = wb_regw && wb_rd != 0;
    last_rd = wb_rd;
    last_d  = wb_data;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("fwd_rs1",      fwd_rs1, e.f1);
      check("fwd_rs2",      fwd_rs2, e.f2);
      check("stall_if",     XLEN'(stall_if),  XLEN'(e.sif));
      check("stall_id",     XLEN'(stall_id),  XLEN'(e.sid));
      check("bubble_ex",    XLEN'(bubble_ex), XLEN'(e.bex));
      check("flush_id",     XLEN'(flush_id),  XLEN'(e.fid));
      check("stall_cycles", XLEN'(stall_cycles), XLEN'(e.sc));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rstn = 1; id_valid = 0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 0; id_rs2_used = 0;
    rf_rs1 = $urandom; rf_rs2 = $urandom;
    ex_regw = 0; ex_is_load = 0; ex_rd = '0; ex_result = $urandom;
    wb_regw = 0; wb_rd = '0; wb_data = $urandom;
    branch_taken = 0;
  endtask

  task automatic load_use_x9();
    quiet();
    id_valid = 1; id_rs1 = 5'd9; id_rs1_used = 1;
    ex_regw = 1; ex_is_load = 1; ex_rd = 5'd9;
  endtask

  initial begin
    quiet();
    rstn = 0;
    repeat (3) begin next_cycle(); quiet(); rstn = 0; push_exp(); end

    // EX forwarding of an ALU result
    next_cycle(); quiet();
    id_valid = 1; id_rs1 = 5'd5; id_rs1_used = 1;
    ex_regw = 1; ex_rd = 5'd5; ex_result = 32'hDEAD0001;
    push_exp();

    // EX beats WB for the same register
    next_cycle(); quiet();
    id_valid = 1; id_rs2 = 5'd7; id_rs2_used = 1;
    ex_regw = 1; ex_rd = 5'd7; ex_result = 32'h11;
    wb_regw = 1; wb_rd = 5'd7; wb_data = 32'h22;
    push_exp();

    // x0 never forwards
    next_cycle(); quiet();
    id_valid = 1; id_rs1 = '0; id_rs1_used = 1;
    ex_regw = 1; ex_rd = '0; ex_result = 32'hBAD0BAD0;
    wb_regw = 1; wb_rd = '0; wb_data = 32'hBAD1BAD1;
    push_exp();
    next_cycle(); quiet(); id_valid = 1; id_rs1_used = 1; push_exp();

    // Load-use: three stall cycles then load data via WB and hold
    next_cycle(); load_use_x9(); push_exp();
    next_cycle(); quiet(); id_valid = 1; id_rs1 = 5'd9; id_rs1_used = 1; push_exp();
    next_cycle(); quiet(); id_valid = 1; id_rs1 = 5'd9; id_rs1_used = 1;
    wb_regw = 1; wb_rd = 5'd9; wb_data = 32'h0BADF00D; push_exp();
    next_cycle(); quiet(); id_valid = 1; id_rs1 = 5'd9; id_rs1_used = 1; rf_rs1 = '0; push_exp();

    // Branch in the second stall cycle, then a suppressed hazard in FLUSH
    next_cycle(); load_use_x9(); push_exp();
    next_cycle(); quiet(); branch_taken = 1; push_exp();
    next_cycle(); load_use_x9(); push_exp();
    next_cycle(); quiet(); push_exp();

    // Back-to-back redirects
    next_cycle(); quiet(); branch_taken = 1; push_exp();
    next_cycle(); quiet(); branch_taken = 1; push_exp();
    next_cycle(); load_use_x9(); push_exp();
    next_cycle(); quiet(); push_exp();

    // Hold register covers stale regfile read
    next_cycle(); quiet(); wb_regw = 1; wb_rd = 5'd3; wb_data = 32'hA5A5A5A5; push_exp();
    next_cycle(); quiet(); id_valid = 1; id_rs1 = 5'd3; id_rs1_used = 1; rf_rs1 = '0; push_exp();

    // Counter saturation, then reset mid-stall
    repeat (20) begin next_cycle(); load_use_x9(); push_exp(); end
    next_cycle(); load_use_x9(); push_exp();
    next_cycle(); load_use_x9(); rstn = 0; push_exp();
    next_cycle(); quiet(); push_exp();
    next_cycle(); quiet(); id_valid = 1; id_rs1 = 5'd3; id_rs1_used = 1; push_exp();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      rstn         = ($urandom_range(0, 99) >= 2);
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs1       = AW'($urandom_range(0, 3));
      id_rs2       = AW'($urandom_range(0, 3));
      id_rs1_used  = $urandom_range(0, 1);
      id_rs2_used  = $urandom_range(0, 1);
      rf_rs1       = $urandom;
      rf_rs2       = $urandom;
      ex_regw      = $urandom_range(0, 1);
      ex_is_load   = ($urandom_range(0, 9) < 3);
      ex_rd        = AW'($urandom_range(0, 3));
      ex_result    = $urandom;
      wb_regw      = $urandom_range(0, 1);
      wb_rd        = AW'($urandom_range(0, 3));
      wb_data      = $urandom;
      branch_taken = ($urandom_range(0, 99) < 8);
      push_exp();
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
